// File: rtl/up_counter_4bit_pkg.sv
// Shared sizing for the shift/add multiplier loop counter.
// The multiplier width and the counter width both come from COUNT_W.
package up_counter_4bit_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] TERMINAL = {COUNT_W{1'b1}};

endpackage

// File: rtl/up_counter_4bit.sv
// Enable-gated binary up-counter that paces the multiplier's shift/add loop.
// K flags the terminal iteration so the controller exits on that cycle.
module up_counter_4bit
  import up_counter_4bit_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CNT,
  output logic             K,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (CNT) begin
      count <= count + 1'b1;
    end
  end

  // Unregistered decode: registering K would delay loop exit by one cycle.
  assign K = (count == {WIDTH{1'b1}});
  assign Q = count;

endmodule

// File: tb/tb_up_counter_4bit.sv
// Self-checking bench for up_counter_4bit: vector table through a scoreboard,
// plus hand sequences for async reset, hold at terminal, priority and the loop contract.
module tb_up_counter_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       CNT;
  logic       K;
  logic [3:0] Q;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       cnt;
    logic [3:0] q;
    logic       k;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       k;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  up_counter_4bit dut (
    .clk(clk),
    .rst(rst),
    .CNT(CNT),
    .K  (K),
    .Q  (Q)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check_q(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: Q got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_k(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: K got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic c, input int q, input logic k);
    vec_t v;
    v.rst = r;
    v.cnt = c;
    v.q   = 4'(q);
    v.k   = k;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;

    // Vector table: sweep, wrap, count to 6, hold, count to 9.
    for (int i = 1; i <= 15; i++) add_vec(1'b0, 1'b1, i, (i == 15));
    add_vec(1'b0, 1'b1, 0, 1'b0);
    for (int i = 1; i <= 6; i++) add_vec(1'b0, 1'b1, i, 1'b0);
    for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0, 6, 1'b0);
    for (int i = 7; i <= 9; i++) add_vec(1'b0, 1'b1, i, 1'b0);

    rst = 1'b1;
    CNT = 1'b0;
    tick();
    tick();
    check_q("reset_q", Q, 4'd0);
    check_k("reset_k", K, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      CNT = vecs[i].cnt;
      e.q = vecs[i].q;
      e.k = vecs[i].k;
      e.idx = i;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check_q($sformatf("vec%0d_q", e.idx), Q, e.q);
      check_k($sformatf("vec%0d_k", e.idx), K, e.k);
    end

    // Async reset mid-cycle from count 9, observed before the next edge.
    CNT = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_q("async_rst9_q", Q, 4'd0);
    check_k("async_rst9_k", K, 1'b0);
    tick();
    rst = 1'b0;

    // Count to 15 then hold: K stays high with CNT low.
    CNT = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    CNT = 1'b0;
    check_q("at15_q", Q, 4'd15);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_q($sformatf("hold15_%0d_q", i), Q, 4'd15);
      check_k($sformatf("hold15_%0d_k", i), K, 1'b1);
    end

    // Async reset from 15 drops K immediately.
    #3;
    rst = 1'b1;
    #1;
    check_q("async_rst15_q", Q, 4'd0);
    check_k("async_rst15_k", K, 1'b0);

    // rst dominates CNT across edges; counting resumes after release.
    CNT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_q($sformatf("prio_%0d_q", i), Q, 4'd0);
    end
    rst = 1'b0;
    tick();
    check_q("prio_release_q", Q, 4'd1);
    CNT = 1'b0;

    // Loop contract: 16 enabled cycles from 0, K only in the 16th.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      CNT = 1'b1;
      check_q($sformatf("loop%0d_q", i), Q, 4'(i));
      check_k($sformatf("loop%0d_k", i), K, (i == 15));
      tick();
    end
    CNT = 1'b0;
    check_q("loop_end_q", Q, 4'd0);
    check_k("loop_end_k", K, 1'b0);
    tick();
    check_q("loop_idle_q", Q, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
